alu_mul_seq: RTL and testbench
==============================

Name: alu_mul_seq

Overview:
- Multi-cycle 8x8 unsigned multiplier built on the existing shared ALU_8_BIT datapath.
- Sequences ALU ops ADD (4'b0000) and RRC (4'b1101) with a shift-and-add schedule.
- Sits beside the register file as a coprocessor and uses valid/ready handshakes on both the operand and the result side.
- Fixed latency, one multiply in flight at a time.

Parameters:
- DATA_W, 8, operand width. Only 8 is supported, to match ALU_8_BIT.
- ITERS, 8, number of shift-add iterations. Must equal DATA_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block idle and able to accept operands.
- op_a  input  8  multiplicand.
- op_b  input  8  multiplier.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  16  unsigned op_a*op_b, as {A,Q}.
- zero  output  1  product == 16'h0000.
- busy  output  1  high in any non-IDLE state.

Behaviour:
- Clock and reset:
  - One clock (clk); reset is synchronous and active-low (rst_n).
  - When rst_n=0 at a clk edge: state=IDLE, and A, Q, M, C and cnt are cleared.
  - Reset values: in_ready=1, out_valid=0, busy=0, product=0, zero=1.
  - Reset mid-operation aborts the multiply; no output is produced.
- Registers:
  - A[7:0] high accumulator, Q[7:0] multiplier/low half, M[7:0] multiplicand.
  - C: 1-bit carry. cnt[2:0]: iteration counter.
- States: IDLE, ADD, RRC_HI, RRC_LO, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: M<=op_a, Q<=op_b, A<=0, C<=0, cnt<=0, state<=ADD.
- ADD:
  - ALU driven with d0=A, d1=M, alu_op=ADD, c_in=0.
  - If Q[0]=1: A<=y, C<=c_out.
  - If Q[0]=0: A unchanged, C<=0. The cycle is still consumed, so latency is fixed.
  - Next state RRC_HI.
- RRC_HI:
  - ALU driven with d0=A, alu_op=RRC, c_in=C.
  - A<=y (={C,A[7:1]}), C<=c_out (=old A[0]).
  - Next state RRC_LO.
- RRC_LO:
  - ALU driven with d0=Q, alu_op=RRC, c_in=C.
  - Q<=y (={old A[0],Q[7:1]}). C is don't-care and is cleared.
  - If cnt==ITERS-1, next state is DONE; otherwise cnt<=cnt+1 and next state is ADD.
  - cnt wraps 7->0 only via a new accept.
- DONE:
  - out_valid=1; product={A,Q} and zero are held stable while out_valid && !out_ready.
  - On out_valid&out_ready: state<=IDLE.
  - in_ready stays 0 until IDLE, so a new operand can be accepted at the earliest one cycle after the handshake.
- Latency:
  - Accept edge, then 24 edges (8×3); out_valid=1 after the 24th edge following accept.
  - Throughput: one product per 26 cycles minimum.
- ALU mux outside the active state: d0=d1=0, alu_op=ADD, c_in=0. ALU outputs are ignored.
- Arithmetic:
  - The sum A+M is 9 bits and its carry is captured in C.
  - The product never exceeds 16'hFE01, so there is no overflow.
- in_valid while busy is ignored; operand inputs are not sampled.
- out_ready asserted with out_valid=0 has no effect.

Decomposition:
- Package alu_pkg:
  - localparams ALU_OP_ADD=4'b0000, ALU_OP_SUB=4'b0001, ALU_OP_RRC=4'b1101.
  - mul_state_t enum {IDLE, ADD, RRC_HI, RRC_LO, DONE}.
- One sub-module: ALU_8_BIT, instantiated unchanged and driven by a combinational operand/op mux.
- The FSM, registers and handshake live in alu_mul_seq.

Test Plan:
- Basic product and latency:
  - Stimulus: op_a=8'h0A, op_b=8'h05, out_ready=1.
  - Required: product=16'h0032, zero=0; out_valid rises exactly 24 edges after the accept edge.
- Full carry propagation:
  - Stimulus: op_a=8'hFF, op_b=8'hFF.
  - Required: product=16'hFE01; exercises c_out=1 on ADD and RRC_HI.
- Zero operand:
  - Stimulus: op_a=8'h00, op_b=8'h37.
  - Required: product=16'h0000, zero=1.
  - Also: op_a=8'h37, op_b=8'h00 gives the same result, with the same 24-edge latency.
- Backpressure:
  - Stimulus: op_a=8'h12, op_b=8'h34, out_ready=0 for 5 cycles after out_valid.
  - Required: product=16'h03A8 held stable and in_ready=0 throughout; IDLE one cycle after out_ready=1.
- Busy rejection and back-to-back:
  - Stimulus: in_valid held high with op_a=8'h81/op_b=8'h02 changing to 8'h03/8'h03 mid-operation.
  - Required: first result 16'h0102 (changed inputs ignored); the second operand pair is accepted only after the first result handshake and yields 16'h0009.
- Reset mid-operation:
  - Stimulus: rst_n=0 for 1 cycle during iteration 4.
  - Required: next cycle shows in_ready=1, out_valid=0, busy=0, product=0; a new multiply of 8'h07*8'h09 then returns 16'h003F.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the sequential multiplier state type.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_OP_RRC = 4'b1101;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    RRC_HI,
    RRC_LO,
    DONE
  } mul_state_t;

endpackage

// File: rtl/ALU_8_BIT.sv
// Shared 8-bit combinational ALU datapath.
// Ports: d0/d1 operands, alu_op opcode, c_in carry in; y result, c_out carry out.
//   ADD: {c_out,y} = d0 + d1 + c_in
//   SUB: {c_out,y} = d0 - d1 - c_in (c_out is the borrow)
//   RRC: y = {c_in, d0[7:1]}, c_out = d0[0]
module ALU_8_BIT
  import alu_pkg::*;
(
  input  logic [7:0]          d0,
  input  logic [7:0]          d1,
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic                c_in,
  output logic [7:0]          y,
  output logic                c_out
);

  always_comb begin
    y     = 8'h00;
    c_out = 1'b0;
    case (alu_op)
      ALU_OP_ADD: {c_out, y} = 9'(d0) + 9'(d1) + 9'(c_in);
      ALU_OP_SUB: {c_out, y} = 9'(d0) - 9'(d1) - 9'(c_in);
      ALU_OP_RRC: begin
        y     = {c_in, d0[7:1]};
        c_out = d0[0];
      end
      default: begin
        y     = 8'h00;
        c_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle 8x8 unsigned shift-and-add multiplier sequencing the shared ALU.
// Each of ITERS iterations takes three cycles: conditional ADD of M into A,
// rotate A right through carry, rotate Q right through carry.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready with op_a/op_b;
//        out_valid/out_ready with product={A,Q} and zero; busy when not IDLE.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ITERS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     op_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_W-1:0]   product,
  output logic                  zero,
  output logic                  busy
);

  localparam int unsigned CNT_W = 3;

  mul_state_t        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic              c_q, c_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              zero_q, zero_d;

  logic [DATA_W-1:0]   alu_d0, alu_d1, alu_y;
  logic [ALU_OP_W-1:0] alu_op;
  logic                alu_cin, alu_cout;

  // Operand/op mux into the shared ALU; idle states drive a quiet ADD of zeros.
  always_comb begin
    alu_d0  = '0;
    alu_d1  = '0;
    alu_op  = ALU_OP_ADD;
    alu_cin = 1'b0;
    case (state_q)
      ADD: begin
        alu_d0 = a_q;
        alu_d1 = m_q;
      end
      RRC_HI: begin
        alu_d0  = a_q;
        alu_op  = ALU_OP_RRC;
        alu_cin = c_q;
      end
      RRC_LO: begin
        alu_d0  = q_q;
        alu_op  = ALU_OP_RRC;
        alu_cin = c_q;
      end
      default: ;
    endcase
  end

  ALU_8_BIT u_alu (
    .d0     (alu_d0),
    .d1     (alu_d1),
    .alu_op (alu_op),
    .c_in   (alu_cin),
    .y      (alu_y),
    .c_out  (alu_cout)
  );

  // Next-state and register update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          m_d     = op_a;
          q_d     = op_b;
          a_d     = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        // The cycle is spent even when Q[0]=0 so latency stays fixed.
        if (q_q[0]) begin
          a_d = alu_y;
          c_d = alu_cout;
        end else begin
          c_d = 1'b0;
        end
        state_d = RRC_HI;
      end
      RRC_HI: begin
        a_d     = alu_y;
        c_d     = alu_cout;
        state_d = RRC_LO;
      end
      RRC_LO: begin
        q_d = alu_y;
        c_d = 1'b0;
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ADD;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    zero_d      = ({a_d, q_d} == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      m_q         <= m_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign zero      = zero_q;
  assign product   = {a_q, q_q};

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: directed cases plus random operands against a*b.
module tb_alu_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        zero;
  logic        busy;

  int total = 0;
  int bad   = 0;

  alu_mul_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .zero      (zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts edges from the accept edge until out_valid is seen (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (out_valid) break;
    end
  endtask

  // One full multiply: accept, fixed latency, optional backpressure, handshake.
  task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input int bp, input string tag);
    logic [15:0] exp_p;
    int n;
    exp_p = 16'(a) * 16'(b);
    out_ready = (bp == 0);
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    check({tag, "_in_ready"}, 16'(in_ready), 16'd1);
    tick();
    in_valid = 1'b0;
    op_a = 8'($urandom);
    op_b = 8'($urandom);
    check({tag, "_busy"}, 16'(busy), 16'd1);
    wait_valid(n);
    check({tag, "_latency"}, 16'(n), 16'd24);
    check({tag, "_product"}, product, exp_p);
    check({tag, "_zero"}, 16'(zero), 16'(exp_p == 16'h0));
    for (int i = 0; i < bp; i++) begin
      tick();
      check({tag, "_hold_valid"}, 16'(out_valid), 16'd1);
      check({tag, "_hold_product"}, product, exp_p);
      check({tag, "_hold_in_ready"}, 16'(in_ready), 16'd0);
    end
    out_ready = 1'b1;
    tick();
    check({tag, "_post_valid"}, 16'(out_valid), 16'd0);
    check({tag, "_post_in_ready"}, 16'(in_ready), 16'd1);
    check({tag, "_post_busy"}, 16'(busy), 16'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0;
    op_a = 8'h00;
    op_b = 8'h00;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_product", product, 16'h0000);
    check("rst_zero", 16'(zero), 16'd1);

    // out_ready without out_valid must not start anything.
    out_ready = 1'b1;
    tick();
    check("idle_ready_busy", 16'(busy), 16'd0);

    do_mul(8'h0A, 8'h05, 0, "basic");
    check("basic_const", 16'h0032, 16'(8'h0A) * 16'(8'h05));
    do_mul(8'hFF, 8'hFF, 0, "full");
    do_mul(8'h00, 8'h37, 0, "zero_a");
    do_mul(8'h37, 8'h00, 0, "zero_b");
    do_mul(8'h12, 8'h34, 5, "bp");

    // Busy rejection: operands change while in_valid stays high.
    out_ready = 1'b1;
    in_valid = 1'b1;
    op_a = 8'h81;
    op_b = 8'h02;
    tick();
    repeat (3) tick();
    op_a = 8'h03;
    op_b = 8'h03;
    check("rej_in_ready", 16'(in_ready), 16'd0);
    wait_valid(n);
    check("rej_latency", 16'(n + 3), 16'd24);
    check("rej_product", product, 16'h0102);
    tick();
    check("rej_handshake_idle", 16'(in_ready), 16'd1);
    check("rej_handshake_valid", 16'(out_valid), 16'd0);
    tick();
    in_valid = 1'b0;
    check("b2b_busy", 16'(busy), 16'd1);
    wait_valid(n);
    check("b2b_latency", 16'(n), 16'd24);
    check("b2b_product", product, 16'h0009);
    tick();

    // Reset during iteration 4.
    in_valid = 1'b1;
    op_a = 8'hC5;
    op_b = 8'h3B;
    tick();
    in_valid = 1'b0;
    repeat (13) tick();
    check("mid_busy", 16'(busy), 16'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_in_ready", 16'(in_ready), 16'd1);
    check("mrst_out_valid", 16'(out_valid), 16'd0);
    check("mrst_busy", 16'(busy), 16'd0);
    check("mrst_product", product, 16'h0000);
    do_mul(8'h07, 8'h09, 0, "after_rst");

    // Random operands with random backpressure.
    for (int k = 0; k < 20; k++) begin
      do_mul(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
